// File: rtl/axis_frame_source_pkg.sv
// rtl/axis_frame_source_pkg.sv - shared encodings and constants for the AXIS frame source
package axis_frame_source_pkg;

  typedef enum logic [1:0] {
    PAT_HRAMP = 2'd0,
    PAT_VRAMP = 2'd1,
    PAT_CHECK = 2'd2,
    PAT_LFSR  = 2'd3
  } pat_e;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    FINISH = 2'd2
  } state_e;

  // Fibonacci taps for x^8+x^6+x^5+x^4+1, left-shifting register
  localparam logic [7:0] LFSR_TAPS         = 8'hB8;
  localparam logic [7:0] LFSR_SEED_DEFAULT = 8'h01;
  localparam int         CHECK_BIT         = 3;

  function automatic logic [7:0] lfsr_step(input logic [7:0] s);
    return {s[6:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/axis_frame_source_pixel_pattern_gen.sv
// rtl/axis_frame_source_pixel_pattern_gen.sv - test-pattern pixel function and LFSR state
module axis_frame_source_pixel_pattern_gen
  import axis_frame_source_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int XW         = 9,
  parameter int YW         = 9
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [XW-1:0]         x_i,
  input  logic [YW-1:0]         y_i,
  input  pat_e                  pattern_i,
  input  logic [7:0]            seed_i,
  input  logic                  reload_i,
  input  logic                  advance_i,
  output logic [DATA_WIDTH-1:0] pixel_o
);

  logic [7:0] lfsr_q;
  logic [7:0] lfsr_d;
  logic [7:0] seed_eff;

  // LFSR next value; the pixel for the coming beat is taken from this so it lines up with x_i/y_i
  always_comb begin
    seed_eff = (seed_i == 8'd0) ? LFSR_SEED_DEFAULT : seed_i;
    lfsr_d   = lfsr_q;
    if (reload_i) begin
      lfsr_d = seed_eff;
    end else if (advance_i) begin
      lfsr_d = lfsr_step(lfsr_q);
    end
  end

  // LFSR state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_q <= LFSR_SEED_DEFAULT;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  // Pixel value for coordinate (x_i, y_i)
  always_comb begin
    pixel_o = '0;
    case (pattern_i)
      PAT_HRAMP: pixel_o = DATA_WIDTH'(x_i);
      PAT_VRAMP: pixel_o = DATA_WIDTH'(y_i);
      PAT_CHECK: pixel_o = (x_i[CHECK_BIT] ^ y_i[CHECK_BIT]) ? {DATA_WIDTH{1'b1}} : '0;
      PAT_LFSR:  pixel_o = DATA_WIDTH'(lfsr_d);
      default:   pixel_o = '0;
    endcase
  end

endmodule

// File: rtl/axis_frame_source.sv
// rtl/axis_frame_source.sv - AXI4-Stream test-pattern frame transmitter
module axis_frame_source
  import axis_frame_source_pkg::*;
#(
  parameter int DATA_WIDTH             = 8,
  parameter int IMAGE_WIDTH_SIZE       = 512,
  parameter int IMAGE_WIDTH_LOG2_SIZE  = 9,
  parameter int IMAGE_HEIGHT_SIZE      = 512,
  parameter int IMAGE_HEIGHT_LOG2_SIZE = 9
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  stop,
  input  logic [1:0]            pattern_sel,
  input  logic [7:0]            seed,
  input  logic [7:0]            num_frames,
  output logic                  busy,
  output logic                  done,
  output logic                  m_axis_tvalid,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tuser,
  output logic                  m_axis_tlast
);

  localparam int XW = IMAGE_WIDTH_LOG2_SIZE;
  localparam int YW = IMAGE_HEIGHT_LOG2_SIZE;
  localparam logic [XW-1:0] XMAX = XW'(IMAGE_WIDTH_SIZE - 1);
  localparam logic [YW-1:0] YMAX = YW'(IMAGE_HEIGHT_SIZE - 1);

  state_e                state_q;
  pat_e                  pat_q;
  logic [7:0]            seed_q;
  logic [7:0]            nf_q;
  logic [7:0]            frame_q;
  logic                  stop_q;
  logic [XW-1:0]         x_q, x_d;
  logic [YW-1:0]         y_q, y_d;
  logic                  tvalid_q, tuser_q, tlast_q, busy_q, done_q;
  logic [DATA_WIDTH-1:0] tdata_q;

  logic                  hs, accept, x_end, y_end, frame_end, last_frame, seq_end;
  logic                  tuser_d, tlast_d, reload;
  pat_e                  pat_cur;
  logic [7:0]            seed_cur;
  logic [DATA_WIDTH-1:0] pixel;

  // Handshake, end-of-line/frame detection and next pixel coordinates
  always_comb begin
    hs         = tvalid_q & m_axis_tready;
    accept     = (state_q == IDLE) & start;
    x_end      = (x_q == XMAX);
    y_end      = (y_q == YMAX);
    frame_end  = hs & x_end & y_end;
    last_frame = stop_q | stop | (frame_q == nf_q - 8'd1);
    seq_end    = frame_end & last_frame;
    reload     = accept | (frame_end & ~last_frame);
    pat_cur    = (state_q == IDLE) ? pat_e'(pattern_sel) : pat_q;
    seed_cur   = (state_q == IDLE) ? seed : seed_q;
    x_d        = x_q;
    y_d        = y_q;
    if (accept) begin
      x_d = '0;
      y_d = '0;
    end else if (hs) begin
      x_d = x_end ? '0 : x_q + XW'(1);
      if (x_end) begin
        y_d = y_end ? '0 : y_q + YW'(1);
      end
    end
    tuser_d = (x_d == XMAX);
    tlast_d = (x_d == XMAX) & (y_d == YMAX);
  end

  axis_frame_source_pixel_pattern_gen #(
    .DATA_WIDTH(DATA_WIDTH),
    .XW        (XW),
    .YW        (YW)
  ) u_gen (
    .clk      (clk),
    .rst_n    (rst_n),
    .x_i      (x_d),
    .y_i      (y_d),
    .pattern_i(pat_cur),
    .seed_i   (seed_cur),
    .reload_i (reload),
    .advance_i(hs),
    .pixel_o  (pixel)
  );

  // Sequencer FSM with counters and registered AXIS/status outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      pat_q    <= PAT_HRAMP;
      seed_q   <= '0;
      nf_q     <= 8'd1;
      frame_q  <= '0;
      stop_q   <= 1'b0;
      x_q      <= '0;
      y_q      <= '0;
      tvalid_q <= 1'b0;
      tdata_q  <= '0;
      tuser_q  <= 1'b0;
      tlast_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      x_q <= x_d;
      y_q <= y_d;
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          stop_q <= 1'b0;
          if (start) begin
            pat_q    <= pat_cur;
            seed_q   <= seed;
            nf_q     <= (num_frames == 8'd0) ? 8'd1 : num_frames;
            frame_q  <= '0;
            busy_q   <= 1'b1;
            tvalid_q <= 1'b1;
            tdata_q  <= pixel;
            tuser_q  <= tuser_d;
            tlast_q  <= tlast_d;
            state_q  <= STREAM;
          end
        end
        STREAM: begin
          if (stop) begin
            stop_q <= 1'b1;
          end
          if (frame_end) begin
            frame_q <= frame_q + 8'd1;
          end
          if (seq_end) begin
            tvalid_q <= 1'b0;
            tuser_q  <= 1'b0;
            tlast_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
            state_q  <= FINISH;
          end else if (hs) begin
            tdata_q <= pixel;
            tuser_q <= tuser_d;
            tlast_q <= tlast_d;
          end
        end
        FINISH: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy          = busy_q;
  assign done          = done_q;
  assign m_axis_tvalid = tvalid_q;
  assign m_axis_tdata  = tdata_q;
  assign m_axis_tuser  = tuser_q;
  assign m_axis_tlast  = tlast_q;

endmodule

// File: tb/tb_axis_frame_source.sv
// tb/tb_axis_frame_source.sv - scoreboard bench for axis_frame_source
module tb_axis_frame_source;

  localparam int W = 16;
  localparam int H = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic [1:0] pattern_sel = 2'd0;
  logic [7:0] seed = 8'd0;
  logic [7:0] num_frames = 8'd0;
  logic       busy, done, tvalid, tuser, tlast;
  logic [7:0] tdata;
  logic       tready = 1'b0;

  axis_frame_source #(
    .DATA_WIDTH(8),
    .IMAGE_WIDTH_SIZE(W),
    .IMAGE_WIDTH_LOG2_SIZE(4),
    .IMAGE_HEIGHT_SIZE(H),
    .IMAGE_HEIGHT_LOG2_SIZE(4)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .stop         (stop),
    .pattern_sel  (pattern_sel),
    .seed         (seed),
    .num_frames   (num_frames),
    .busy         (busy),
    .done         (done),
    .m_axis_tvalid(tvalid),
    .m_axis_tdata (tdata),
    .m_axis_tready(tready),
    .m_axis_tuser (tuser),
    .m_axis_tlast (tlast)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    logic       user;
    logic       last;
    logic       fin;
  } beat_t;

  beat_t exp_q[$];
  int    errors = 0;
  int    checks = 0;
  int    cyc = 0;
  int    beats_seen = 0;
  int    done_seen = 0;
  int    done_cyc = 0;
  int    start_cyc = 0;
  bit    ready_random = 1'b0;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  // Reference polynomial x^8+x^6+x^5+x^4+1: feedback from stages 8,6,5,4
  function automatic logic [7:0] model_lfsr(input logic [7:0] s);
    int fb;
    fb = ((s >> 7) + (s >> 5) + (s >> 4) + (s >> 3)) % 2;
    return 8'((int'(s) * 2) % 256 + fb);
  endfunction

  task automatic push_seq(input int pat, input logic [7:0] sd, input int frames);
    beat_t      e;
    logic [7:0] s;
    for (int f = 0; f < frames; f++) begin
      s = (sd == 8'd0) ? 8'd1 : sd;
      for (int y = 0; y < H; y++) begin
        for (int x = 0; x < W; x++) begin
          case (pat)
            0: e.data = 8'(x % 256);
            1: e.data = 8'(y % 256);
            2: e.data = (((x / 8) % 2) != ((y / 8) % 2)) ? 8'hFF : 8'h00;
            default: e.data = s;
          endcase
          e.user = (x == W - 1);
          e.last = (x == W - 1) && (y == H - 1);
          e.fin  = e.last && (f == frames - 1);
          exp_q.push_back(e);
          s = model_lfsr(s);
        end
      end
    end
  endtask

  // tready driver
  initial begin
    forever begin
      @(posedge clk);
      #1;
      tready = ready_random ? ($urandom_range(0, 3) != 0) : 1'b1;
    end
  end

  // Monitor: pops expected beats on handshakes, checks stalls and done
  initial begin
    beat_t e;
    beat_t prev;
    bit    prev_stall;
    bit    prev_fin;
    prev_stall = 1'b0;
    prev_fin   = 1'b0;
    prev.data  = 8'd0;
    prev.user  = 1'b0;
    prev.last  = 1'b0;
    prev.fin   = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_stall = 1'b0;
        prev_fin   = 1'b0;
      end else begin
        if (prev_fin) begin
          check("done_pulse", done, 1);
          check("tvalid_after_end", tvalid, 0);
          check("busy_after_end", busy, 0);
          done_seen++;
          done_cyc = cyc;
          prev_fin = 1'b0;
        end else if (done) begin
          check("spurious_done", done, 0);
        end
        if (prev_stall) begin
          check("hold_valid", tvalid, 1);
          check("hold_data", tdata, prev.data);
          check("hold_user", tuser, prev.user);
          check("hold_last", tlast, prev.last);
        end
        if (tvalid && tready) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_beat: got data %0h, required no beat", tdata);
          end else begin
            e = exp_q.pop_front();
            check("beat_data", tdata, e.data);
            check("beat_user", tuser, e.user);
            check("beat_last", tlast, e.last);
            prev_fin = e.fin;
          end
          beats_seen++;
        end
        prev_stall = tvalid && !tready;
        prev.data  = tdata;
        prev.user  = tuser;
        prev.last  = tlast;
      end
    end
  end

  task automatic launch(input logic [1:0] pat, input logic [7:0] sd, input logic [7:0] nf);
    @(posedge clk);
    #1;
    start       = 1'b1;
    pattern_sel = pat;
    seed        = sd;
    num_frames  = nf;
    start_cyc   = cyc + 1;
    @(posedge clk);
    #1;
    start       = 1'b0;
    pattern_sel = 2'($urandom);
    seed        = 8'($urandom);
    num_frames  = 8'($urandom);
    @(negedge clk);
    check("busy_after_start", busy, 1);
    check("valid_after_start", tvalid, 1);
  endtask

  task automatic wait_done(input int base, input int limit);
    int n;
    n = 0;
    while (done_seen <= base && n < limit) begin
      @(posedge clk);
      n++;
    end
    if (done_seen <= base) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: got no done after %0d cycles, required done", limit);
      exp_q.delete();
    end
    repeat (3) @(posedge clk);
  endtask

  task automatic wait_beats(input int target, input int limit);
    int n;
    n = 0;
    while (beats_seen < target && n < limit) begin
      @(posedge clk);
      n++;
    end
    if (beats_seen < target) begin
      checks++;
      errors++;
      $display("FAIL beat_timeout: got %0d beats, required %0d", beats_seen, target);
    end
  endtask

  initial begin
    int base;
    int b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_tvalid", tvalid, 0);
    check("rst_tdata", tdata, 0);
    check("rst_tuser", tuser, 0);
    check("rst_tlast", tlast, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    #2 rst_n = 1'b1;

    // Horizontal ramp at full throughput
    ready_random = 1'b0;
    base = done_seen;
    push_seq(0, 8'd0, 1);
    launch(2'd0, 8'd0, 8'd1);
    wait_done(base, 2000);
    check("throughput_cycles", 32'(done_cyc - start_cyc), W * H);

    // Vertical ramp, num_frames 0 behaves as 1, random backpressure
    ready_random = 1'b1;
    base = done_seen;
    push_seq(1, 8'd0, 1);
    launch(2'd1, 8'd0, 8'd0);
    wait_done(base, 4000);

    // Checkerboard, two frames
    base = done_seen;
    push_seq(2, 8'd0, 2);
    launch(2'd2, 8'd0, 8'd2);
    wait_done(base, 6000);

    // LFSR seed 0, two identical frames, start while busy ignored
    base = done_seen;
    b0 = beats_seen;
    push_seq(3, 8'd0, 2);
    launch(2'd3, 8'd0, 8'd2);
    wait_beats(b0 + 50, 2000);
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    wait_done(base, 6000);

    // Stop in IDLE ignored, then LFSR with nonzero seed
    @(posedge clk);
    #1 stop = 1'b1;
    @(posedge clk);
    #1 stop = 1'b0;
    base = done_seen;
    push_seq(3, 8'hA5, 1);
    launch(2'd3, 8'hA5, 8'd1);
    wait_done(base, 4000);

    // Five frames requested, stop in frame 2 ends after frame 2
    base = done_seen;
    b0 = beats_seen;
    push_seq(1, 8'd0, 2);
    launch(2'd1, 8'd0, 8'd5);
    wait_beats(b0 + W * H + 100, 4000);
    @(posedge clk);
    #1 stop = 1'b1;
    @(posedge clk);
    #1 stop = 1'b0;
    wait_done(base, 6000);
    check("stop_done_count", 32'(done_seen - base), 1);

    // Asynchronous reset mid-frame
    b0 = beats_seen;
    push_seq(0, 8'd0, 1);
    launch(2'd0, 8'd0, 8'd1);
    wait_beats(b0 + 5, 1000);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_tvalid", tvalid, 0);
    check("arst_tuser", tuser, 0);
    check("arst_tlast", tlast, 0);
    check("arst_busy", busy, 0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    #2 rst_n = 1'b1;

    // Restart after reset begins again at (0,0)
    base = done_seen;
    push_seq(0, 8'd0, 1);
    launch(2'd0, 8'd0, 8'd1);
    wait_done(base, 4000);

    check("queue_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
